// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game sequencer and the rest of the game.
// The master side drives the player/playfield events; the slave side is the sequencer.
interface game_sequencer_if;
  logic       start_btn;
  logic       collision;
  logic       pipe_passed;
  logic [1:0] state;
  logic       scroll_tick;
  logic       pipes_reset;
  logic       bird_enable;
  logic [7:0] score;
  logic [7:0] high_score;

  modport master (
    output start_btn, collision, pipe_passed,
    input  state, scroll_tick, pipes_reset, bird_enable, score, high_score
  );

  modport slave (
    input  start_btn, collision, pipe_passed,
    output state, scroll_tick, pipes_reset, bird_enable, score, high_score
  );
endinterface

// File: rtl/game_sequencer.sv
// Game flow sequencer: READY -> PLAYING -> DYING -> OVER -> READY, with scroll
// timing, BCD score keeping and high-score tracking. All outputs are registered.
module game_sequencer #(
  parameter int TICK_DIV   = 1_000_000,
  parameter int DEATH_HOLD = 60
) (
  input  logic              clk,
  input  logic              reset,
  game_sequencer_if.slave   bus
);

  localparam int               DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(DEATH_HOLD);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [7:0]       hold_reg, hold_next;
  logic [7:0]       score_reg, score_next;
  logic [7:0]       high_score_reg, high_score_next;
  logic             start_prev_reg;
  logic             scroll_tick_reg, scroll_tick_next;
  logic             pipes_reset_reg, pipes_reset_next;
  logic             bird_enable_reg, bird_enable_next;
  logic             press;
  logic             div_wrap;

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= READY;
      div_reg         <= '0;
      hold_reg        <= '0;
      score_reg       <= 8'h00;
      high_score_reg  <= 8'h00;
      // Preset high so a button held through reset is not seen as a press.
      start_prev_reg  <= 1'b1;
      scroll_tick_reg <= 1'b0;
      pipes_reset_reg <= 1'b1;
      bird_enable_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      div_reg         <= div_next;
      hold_reg        <= hold_next;
      score_reg       <= score_next;
      high_score_reg  <= high_score_next;
      start_prev_reg  <= bus.start_btn;
      scroll_tick_reg <= scroll_tick_next;
      pipes_reset_reg <= pipes_reset_next;
      bird_enable_reg <= bird_enable_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    div_next         = div_reg;
    hold_next        = hold_reg;
    score_next       = score_reg;
    high_score_next  = high_score_reg;
    pipes_reset_next = 1'b0;
    press            = bus.start_btn & ~start_prev_reg;
    div_wrap         = (div_reg == DIV_LAST);

    case (state_reg)
      READY: begin
        if (press) begin
          state_next = PLAYING;
          score_next = 8'h00;
          div_next   = '0;
        end
      end
      PLAYING: begin
        if (bus.collision) begin
          // Collision beats a simultaneous pass; the pre-pass score is final.
          state_next = DYING;
          div_next   = '0;
          hold_next  = '0;
          if (score_reg > high_score_reg)
            high_score_next = score_reg;
        end else begin
          div_next = div_wrap ? '0 : div_reg + 1'b1;
          if (bus.pipe_passed)
            score_next = bcd_inc(score_reg);
        end
      end
      DYING: begin
        div_next = div_wrap ? '0 : div_reg + 1'b1;
        if (div_wrap) begin
          hold_next = hold_reg + 8'd1;
          if (hold_reg + 8'd1 == HOLD_LAST) begin
            state_next = OVER;
            div_next   = '0;
            hold_next  = '0;
          end
        end
      end
      OVER: begin
        if (press) begin
          state_next       = READY;
          pipes_reset_next = 1'b1;
        end
      end
      default: state_next = READY;
    endcase

    // Decoded from next-state values so the registered outputs line up with state.
    scroll_tick_next = (state_next == PLAYING) && (div_next == DIV_LAST);
    bird_enable_next = (state_next == PLAYING);
  end

  assign bus.state       = state_reg;
  assign bus.scroll_tick = scroll_tick_reg;
  assign bus.pipes_reset = pipes_reset_reg;
  assign bus.bird_enable = bird_enable_reg;
  assign bus.score       = score_reg;
  assign bus.high_score  = high_score_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios followed by random play,
// every cycle compared against a cycle-count based model of the game rules.
module tb_game_sequencer;

  localparam int TD = 4;
  localparam int DH = 2;

  logic clk = 1'b0;
  logic reset;

  game_sequencer_if bus ();

  game_sequencer #(.TICK_DIV(TD), .DEATH_HOLD(DH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: decimal scores, state as 0..3, m_cnt = edges since entering PLAYING/DYING.
  int m_state, m_score, m_high, m_cnt;
  bit m_prev, m_tick, m_pres, m_bird;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_high = 0; m_cnt = 0;
    m_prev = 1'b1; m_tick = 1'b0; m_pres = 1'b1; m_bird = 1'b0;
  endtask

  task automatic model_edge(input bit btn, input bit col, input bit pp);
    bit pr;
    pr     = btn && !m_prev;
    m_prev = btn;
    m_pres = 1'b0;
    case (m_state)
      0: if (pr) begin m_state = 1; m_score = 0; m_cnt = 0; end
      1: begin
        if (col) begin
          m_state = 2; m_cnt = 0;
          if (m_score > m_high) m_high = m_score;
        end else begin
          if (pp && m_score < 99) m_score++;
          m_cnt++;
        end
      end
      2: begin
        m_cnt++;
        if (m_cnt == DH * TD) m_state = 3;
      end
      default: if (pr) begin m_state = 0; m_pres = 1'b1; end
    endcase
    // Tick lands on every TD-th cycle spent in PLAYING, counting the entry cycle as 1.
    m_tick = (m_state == 1) && (((m_cnt + 1) % TD) == 0);
    m_bird = (m_state == 1);
  endtask

  task automatic compare_all();
    check("state",       32'(bus.state),       32'(m_state));
    check("score",       32'(bus.score),       32'(to_bcd(m_score)));
    check("high_score",  32'(bus.high_score),  32'(to_bcd(m_high)));
    check("scroll_tick", 32'(bus.scroll_tick), 32'(m_tick));
    check("pipes_reset", 32'(bus.pipes_reset), 32'(m_pres));
    check("bird_enable", 32'(bus.bird_enable), 32'(m_bird));
  endtask

  task automatic step(input bit btn, input bit col, input bit pp);
    bus.start_btn   = btn;
    bus.collision   = col;
    bus.pipe_passed = pp;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(btn, col, pp);
    #1;
    compare_all();
    $display("t=%0t rst=%0b btn=%0b col=%0b pp=%0b state=%0d score=%02h high=%02h tick=%0b pres=%0b bird=%0b",
             $time, reset, btn, col, pp, bus.state, bus.score, bus.high_score,
             bus.scroll_tick, bus.pipes_reset, bus.bird_enable);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_over(input string tag, output int n);
    n = 0;
    while (bus.state != 2'd3 && n < 40) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 40) check({tag, "_timeout"}, 32'(bus.state), 32'd3);
  endtask

  initial begin
    int n;
    int cyc;
    bit btn, col, pp;

    reset = 1'b1;
    bus.start_btn = 1'b1; bus.collision = 1'b0; bus.pipe_passed = 1'b0;
    model_reset();

    // Button held through reset and release: no press may be seen.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rst_pres_high", 32'(bus.pipes_reset), 32'd1);
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("release_pres_low", 32'(bus.pipes_reset), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("held_btn_ready", 32'(bus.state), 32'd0);

    // Start and scroll timing.
    step(1'b1, 1'b0, 1'b0);
    check("start_playing", 32'(bus.state), 32'd1);
    check("start_bird", 32'(bus.bird_enable), 32'd1);
    for (cyc = 2; cyc <= 9; cyc++) begin
      step(1'b0, 1'b0, 1'b0);
      check("tick_cycle", 32'(bus.scroll_tick), 32'((cyc % TD) == 0));
    end

    // Scoring, BCD carry and saturation.
    pulses(12);
    check("score_12", 32'(bus.score), 32'h12);
    while (m_score < 99) pulses(1);
    check("score_99", 32'(bus.score), 32'h99);
    pulses(1);
    check("score_sat", 32'(bus.score), 32'h99);

    // Die, then reset asynchronously between edges mid-DYING.
    step(1'b0, 1'b1, 1'b0);
    check("die_99_high", 32'(bus.high_score), 32'h99);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("async_state", 32'(bus.state), 32'd0);
    check("async_high", 32'(bus.high_score), 32'h00);
    check("async_pres", 32'(bus.pipes_reset), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Game 2: simultaneous collision and pass at score 07.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    pulses(7);
    step(1'b0, 1'b1, 1'b1);
    check("die_state", 32'(bus.state), 32'd2);
    check("die_score", 32'(bus.score), 32'h07);
    check("die_high", 32'(bus.high_score), 32'h07);
    wait_over("over1", n);
    check("over_latency", 32'(n), 32'(DH * TD));

    // OVER -> READY with a single pipes_reset pulse, then a weaker game.
    step(1'b1, 1'b0, 1'b0);
    check("over_to_ready", 32'(bus.state), 32'd0);
    check("ready_pres", 32'(bus.pipes_reset), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("ready_pres_drop", 32'(bus.pipes_reset), 32'd0);
    check("ready_score_hold", 32'(bus.score), 32'h07);
    step(1'b1, 1'b0, 1'b0);
    check("restart_score", 32'(bus.score), 32'h00);
    step(1'b0, 1'b0, 1'b0);
    pulses(3);
    step(1'b0, 1'b1, 1'b0);
    check("low_score", 32'(bus.score), 32'h03);
    check("high_kept", 32'(bus.high_score), 32'h07);
    wait_over("over2", n);

    // Random play against the model.
    for (int i = 0; i < 1500; i++) begin
      btn = ($urandom_range(0, 5) == 0);
      col = ($urandom_range(0, 29) == 0);
      pp  = ($urandom_range(0, 2) == 0);
      step(btn, col, pp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1_000_000: clk cycles per scroll step, legal range 2..2^22.
REQ-002 The block SHALL have parameter DEATH_HOLD, default 60: scroll-step periods spent in DYING, legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start_btn  input  1  button level, already synchronous to clk.
REQ-006 The block SHALL have port collision  input  1  bird/pipe overlap, level.
REQ-007 The block SHALL have port pipe_passed  input  1  one-cycle pulse when a pipe clears the bird column.
REQ-008 The block SHALL have port state  output  2  current state: 0 READY, 1 PLAYING, 2 DYING, 3 OVER.
REQ-009 The block SHALL have port scroll_tick  output  1  one-cycle pulse that advances pipes and bird by one step.
REQ-010 The block SHALL have port pipes_reset  output  1  one-cycle pulse that returns pipes to spawn positions.
REQ-011 The block SHALL have port bird_enable  output  1  high only in PLAYING; gates the bird physics.
REQ-012 The block SHALL have port score  output  8  current score, two BCD digits {tens, ones}.
REQ-013 The block SHALL have port high_score  output  8  best score since reset, two BCD digits.

Function
REQ-014 The block SHALL detect a start press as start_btn=1 while the registered previous start_btn=0; the previous-value register SHALL reset to 1, so a button held through reset produces no press.
REQ-015 READY SHALL go to PLAYING on a start press; in that same edge score SHALL clear to 0x00 and the divider SHALL clear to 0.
REQ-016 In PLAYING the divider SHALL count 0..TICK_DIV-1 and wrap; scroll_tick SHALL be 1 exactly in the cycle the divider equals TICK_DIV-1, so the first tick comes TICK_DIV cycles after entry.
REQ-017 In PLAYING, collision=1 SHALL cause DYING on the next edge; the divider and the hold counter SHALL clear to 0.
REQ-018 In PLAYING, pipe_passed=1 with collision=0 SHALL add 1 to score in BCD: ones 9 wraps to 0 and carries to tens.
REQ-019 Score SHALL saturate at 0x99; a pass at 0x99 SHALL leave it at 0x99.
REQ-020 If collision and pipe_passed are both 1 in the same cycle, collision SHALL win and score SHALL NOT increment.
REQ-021 pipe_passed SHALL be ignored in every state except PLAYING.
REQ-022 On the edge entering DYING, if score > high_score (BCD compare, tens first), high_score SHALL load score.
REQ-023 In DYING the divider SHALL keep running, scroll_tick SHALL stay 0, and the hold counter SHALL increment on each divider wrap.
REQ-024 DYING SHALL go to OVER on the wrap where the hold counter reaches DEATH_HOLD, i.e. DEATH_HOLD*TICK_DIV cycles after entry.
REQ-025 Start presses SHALL be ignored in PLAYING and DYING, but the edge-detect register SHALL keep tracking start_btn.
REQ-026 OVER SHALL go to READY on a start press; pipes_reset SHALL be 1 for exactly the one cycle after that edge.
REQ-027 score SHALL hold its value through DYING, OVER and READY until the next READY-to-PLAYING transition.
REQ-028 bird_enable SHALL be a registered decode equal to (state==PLAYING).
REQ-029 scroll_tick, pipes_reset, state, score and high_score SHALL all be registered outputs.

Reset
REQ-030 While reset=1 the block SHALL force state=READY, score=0x00, high_score=0x00, scroll_tick=0, bird_enable=0, divider=0, hold counter=0 and start-previous=1.
REQ-031 While reset=1, pipes_reset SHALL be 1, and it SHALL fall to 0 on the first clk edge after reset deasserts.
REQ-032 Reset asserted in any state, including mid-DYING, SHALL take effect immediately and discard all counters.

Verification (TICK_DIV=4, DEATH_HOLD=2)
REQ-033 The bench SHALL apply reset, hold start_btn=1 through release, then drop it -> state stays READY; pipes_reset pulses once at release.
REQ-034 The bench SHALL press start once -> PLAYING next edge; scroll_tick pulses every 4 cycles, first at cycle 4 after entry; bird_enable=1.
REQ-035 The bench SHALL apply 12 pipe_passed pulses in PLAYING -> score=0x12; from 0x99 one more pulse -> score stays 0x99.
REQ-036 The bench SHALL assert collision and pipe_passed together with score=0x07 -> DYING, score=0x07, high_score=0x07; scroll_tick stays 0; OVER exactly 8 cycles after DYING entry.
REQ-037 The bench SHALL press start in OVER -> READY with a one-cycle pipes_reset; press start again -> score=0x00, and high_score keeps 0x07 after a later death with score 0x03.
REQ-038 The bench SHALL assert reset asynchronously mid-DYING -> outputs match REQ-030 before the next clk edge.
